mult_div_unit: RTL and testbench

//  - E-stage multiply/divide unit (MDU) of the 5-stage MIPS pipeline. Owns HI/LO and models

---
 rtl/mult_div_unit.sv | 155 +++++++++++++++
 tb/tb_mult_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit that owns HI/LO and holds Busy while an op is in flight.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MADD_EN.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        pend_wr;
  logic [63:0] pend;

  logic        op_ok;
  logic        op_wr;
  logic [3:0]  op_cycles;
  logic [63:0] op_res;

  function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return 64'(sa * sb);
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua;
    logic [63:0] ub;
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // {remainder, quotient}; quotient truncates toward zero, remainder follows dividend sign
  function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  always_comb begin
    op_ok     = 1'b0;
    op_wr     = 1'b1;
    op_cycles = MC;
    op_res    = 64'd0;
    case (MDOp)
      OP_MULT:  begin op_ok = 1'b1; op_res = mul_s(A, B); end
      OP_MULTU: begin op_ok = 1'b1; op_res = mul_u(A, B); end
      OP_DIV: begin
        op_ok = 1'b1;
        op_cycles = DC;
        op_wr = (B != 32'd0);
        if (B != 32'd0) op_res = div_s(A, B);
      end
      OP_DIVU: begin
        op_ok = 1'b1;
        op_cycles = DC;
        op_wr = (B != 32'd0);
        if (B != 32'd0) op_res = div_u(A, B);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin op_ok = 1'b1; op_res = {HI, LO} + mul_s(A, B); end
      OP_MADDU: begin op_ok = 1'b1; op_res = {HI, LO} + mul_u(A, B); end
      OP_MSUB:  begin op_ok = 1'b1; op_res = {HI, LO} - mul_s(A, B); end
      OP_MSUBU: begin op_ok = 1'b1; op_res = {HI, LO} - mul_u(A, B); end
`endif
      default: op_ok = 1'b0;
    endcase
  end

  // Issue: result computed and parked at the Start edge
  always_ff @(posedge clk) begin
    if (state == IDLE && Start && op_ok) pend <= op_res;
  end

  // Countdown and HI/LO commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      Busy    <= 1'b0;
      pend_wr <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start && op_ok) begin
            state   <= RUN;
            cnt     <= op_cycles;
            Busy    <= 1'b1;
            pend_wr <= op_wr;
          end else if (!Start && MDOp == OP_MTHI) begin
            HI <= A;
          end else if (!Start && MDOp == OP_MTLO) begin
            LO <= A;
          end
        end
        RUN: begin
          if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            cnt   <= 4'd0;
            Busy  <= 1'b0;
            if (pend_wr) {HI, LO} <= pend;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; MDU_MADD_EN selects the accumulate checks.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_n;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] val);
    MDOp = op; A = val; Start = 1'b0;
    step();
    MDOp = 4'd0; A = 32'h0;
  endtask

  // Pulse Start, scramble operands, count Busy cycles; optionally inject a second Start
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, output int cycles);
    Start = 1'b1; MDOp = op; A = a; B = b;
    step();
    Start = 1'b0; MDOp = 4'd0; A = 32'hA5A5_5A5A; B = 32'h0000_0003;
    cycles = 0;
    while (Busy && cycles < 40) begin
      cycles++;
      if (cycles == inj_at) begin
        Start = 1'b1; MDOp = 4'd1; A = 32'd3; B = 32'd5;
      end
      step();
      Start = 1'b0; MDOp = 4'd0;
    end
  endtask

  initial begin
    reset_n = 1'b0; Start = 1'b0; MDOp = 4'd0; A = 32'h0; B = 32'h0;
    step(); step();
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    reset_n = 1'b1;
    step();

    // Reset during a divide aborts it and clears HI
    mt(4'd5, 32'h55);
    chk("mthi_pre", {32'd0, HI}, 64'h55);
    Start = 1'b1; MDOp = 4'd4; A = 32'd7; B = 32'd2;
    step();
    Start = 1'b0; MDOp = 4'd0;
    step(); step(); step();
    chk("abort_busy_pre", {63'd0, Busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_hilo", {HI, LO}, 64'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("abort_idle_busy", {63'd0, Busy}, 64'd0);
    chk("abort_idle_hilo", {HI, LO}, 64'd0);

    // Multiply
    run_op(4'd1, 32'd3, 32'hFFFF_FFFC, -1, cyc);
    chk("mult_cycles", 64'(cyc), 64'd5);
    chk("mult_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF4);
    run_op(4'd2, 32'd3, 32'hFFFF_FFFC, -1, cyc);
    chk("multu_cycles", 64'(cyc), 64'd5);
    chk("multu_hilo", {HI, LO}, 64'h0000_0002_FFFF_FFF4);

    // Divide
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, -1, cyc);
    chk("div_cycles", 64'(cyc), 64'd10);
    chk("div_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd4, 32'd7, 32'd2, -1, cyc);
    chk("divu_cycles", 64'(cyc), 64'd10);
    chk("divu_hilo", {HI, LO}, 64'h0000_0001_0000_0003);

    // Divide by zero, with an ignored Start mid-flight
    mt(4'd5, 32'h11);
    mt(4'd6, 32'h22);
    chk("mt_setup", {HI, LO}, 64'h0000_0011_0000_0022);
    run_op(4'd3, 32'd100, 32'd0, 3, cyc);
    chk("div0_cycles", 64'(cyc), 64'd10);
    chk("div0_hilo", {HI, LO}, 64'h0000_0011_0000_0022);
    step();
    chk("div0_after_busy", {63'd0, Busy}, 64'd0);

    // Non-compute op with Start is ignored
    Start = 1'b1; MDOp = 4'd12; A = 32'd9; B = 32'd9;
    step();
    Start = 1'b0; MDOp = 4'd0;
    chk("nop_busy", {63'd0, Busy}, 64'd0);
    chk("nop_hilo", {HI, LO}, 64'h0000_0011_0000_0022);

    // MTHI / MTLO back to back, then MTLO while busy
    MDOp = 4'd5; A = 32'hDEAD_BEEF;
    step();
    chk("mthi_hi", {32'd0, HI}, 64'hDEAD_BEEF);
    chk("mthi_busy", {63'd0, Busy}, 64'd0);
    MDOp = 4'd6; A = 32'h1234_5678;
    step();
    MDOp = 4'd0;
    chk("mtlo_lo", {32'd0, LO}, 64'h1234_5678);
    chk("mtlo_busy", {63'd0, Busy}, 64'd0);
    Start = 1'b1; MDOp = 4'd4; A = 32'd1; B = 32'd0;
    step();
    Start = 1'b0; MDOp = 4'd6; A = 32'hAAAA_AAAA;
    step(); step();
    MDOp = 4'd0;
    cyc = 0;
    while (Busy && cyc < 40) begin cyc++; step(); end
    chk("mtlo_busy_ignored", {HI, LO}, 64'hDEAD_BEEF_1234_5678);

    // Accumulate ops
    mt(4'd5, 32'h0);
    mt(4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op(4'd8, 32'd1, 32'd1, -1, cyc);
    chk("maddu_cycles", 64'(cyc), 64'd5);
    chk("maddu_hilo", {HI, LO}, 64'h0000_0001_0000_0000);
    run_op(4'd9, 32'd1, 32'd1, -1, cyc);
    chk("msub_hilo", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, -1, cyc);
    chk("madd_hilo", {HI, LO}, 64'h0000_0000_FFFF_FFFE);
`else
    Start = 1'b1; MDOp = 4'd8; A = 32'd1; B = 32'd1;
    step();
    Start = 1'b0; MDOp = 4'd0;
    chk("maddu_off_busy", {63'd0, Busy}, 64'd0);
    step(); step(); step(); step(); step();
    chk("maddu_off_hilo", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
